// File: rtl/br_line_port.sv
`default_nettype none
// ============================================================================
// Module      : br_line_port
// Description : Turns one cache-line read/write request into one burst RAM
//               command, streams write beats out and gathers read beats in.
// Revision    : 1.0 - initial release
// ============================================================================
module br_line_port #(
    parameter int ADDR_WIDTH          = 21,
    parameter int BEAT_WIDTH          = 64,
    parameter int BEATS_PER_LINE      = 4,
    parameter int CMD_GAP_CYCLES      = 14,
    parameter int READ_TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 calib_done,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_write,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [BEATS_PER_LINE*BEAT_WIDTH-1:0] req_wdata,
    output logic                                 rsp_valid,
    output logic [BEATS_PER_LINE*BEAT_WIDTH-1:0] rsp_rdata,
    output logic                                 rsp_error,
    output logic                                 stray_beat,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [ADDR_WIDTH-1:0]                br_addr,
    output logic [BEAT_WIDTH-1:0]                br_wr_data,
    output logic [BEAT_WIDTH/8-1:0]              br_data_mask,
    input  logic [BEAT_WIDTH-1:0]                br_rd_data,
    input  logic                                 br_rd_data_valid
);
    localparam int c_LINE_W = BEATS_PER_LINE * BEAT_WIDTH;
    localparam int c_CNT_W  = $clog2(BEATS_PER_LINE + 1);
    localparam int c_GAP_W  = (CMD_GAP_CYCLES > 0) ? $clog2(CMD_GAP_CYCLES + 1) : 1;
    localparam int c_TMR_W  = $clog2(READ_TIMEOUT_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BEATS_PER_LINE);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE   = c_GAP_W'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD  = c_GAP_W'(CMD_GAP_CYCLES);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(READ_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_BEATS = 2'd1,
        S_RD_WAIT  = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_GAP_W-1:0]    r_gap;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_TMR_W-1:0]    r_tmr;
    logic [c_LINE_W-1:0]   r_wdata;
    logic [c_LINE_W-1:0]   r_line;
    logic                  r_cmd;
    logic                  r_cmd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BEAT_WIDTH-1:0] r_wr_data;
    logic                  r_rsp_valid;
    logic                  r_rsp_error;
    logic                  r_stray;

    logic w_accept;
    logic w_rd_beat;
    logic w_rd_last;
    logic w_wr_last;
    logic w_timeout;
    logic w_done;

    assign req_ready = (r_state == S_IDLE) && (r_gap == '0) && calib_done;
    assign w_accept  = req_valid && req_ready;
    assign w_rd_beat = br_rd_data_valid && (r_state == S_RD_WAIT);
    assign w_rd_last = w_rd_beat && (r_cnt == (c_LAST_BEAT - c_CNT_ONE));
    assign w_wr_last = (r_state == S_WR_BEATS) && (r_cnt == c_LAST_BEAT);
    // A final beat landing on the timeout cycle still completes the line.
    assign w_timeout = (r_state == S_RD_WAIT) && (r_tmr == c_TMR_LAST) && !w_rd_last;
    assign w_done    = w_wr_last || w_rd_last || w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_nxt = req_write ? S_WR_BEATS : S_RD_WAIT;
            S_WR_BEATS: if (w_wr_last) w_state_nxt = S_GAP;
            S_RD_WAIT:  if (w_rd_last || w_timeout) w_state_nxt = S_GAP;
            S_GAP:      if (r_gap <= c_GAP_ONE) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap       <= '0;
            r_cnt       <= '0;
            r_tmr       <= '0;
            r_wdata     <= '0;
            r_line      <= '0;
            r_cmd       <= 1'b0;
            r_cmd_en    <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_stray     <= 1'b0;
        end else begin
            r_cmd_en    <= 1'b0;
            r_rsp_valid <= w_done;
            r_rsp_error <= w_timeout;

            if (w_accept) begin
                r_cmd_en  <= 1'b1;
                r_cmd     <= req_write;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_wr_data <= req_wdata[BEAT_WIDTH-1:0];
                r_cnt     <= req_write ? c_CNT_ONE : '0;
                r_tmr     <= '0;
            end

            if ((r_state == S_WR_BEATS) && !w_wr_last) begin
                r_wr_data <= r_wdata[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH];
                r_cnt     <= r_cnt + c_CNT_ONE;
            end

            if (r_state == S_RD_WAIT) begin
                r_tmr <= r_tmr + c_TMR_ONE;
            end

            if (w_rd_beat) begin
                r_line[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= br_rd_data;
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (w_timeout) begin
                r_line <= '0;
            end

            if (w_done) begin
                r_gap <= c_GAP_LOAD;
            end else if ((r_state == S_GAP) && (r_gap != '0)) begin
                r_gap <= r_gap - c_GAP_ONE;
            end

            if (br_rd_data_valid && (r_state != S_RD_WAIT)) begin
                r_stray <= 1'b1;
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_error    = r_rsp_error;
    assign rsp_rdata    = r_line;
    assign stray_beat   = r_stray;
    assign br_cmd       = r_cmd;
    assign br_cmd_en    = r_cmd_en;
    assign br_addr      = r_addr;
    assign br_wr_data   = r_wr_data;
    assign br_data_mask = '0;

endmodule
`default_nettype wire
